// File: rtl/dsp_fractured_result_sat_packer.sv
// Two-lane saturate/truncate packer with a small output FIFO on a valid/ready stream.
// Optional macro DSP_PACK_SYMMETRIC_SAT_EN selects a symmetric negative clamp value.
module dsp_fractured_result_sat_packer #(
    parameter int unsigned LANE_W     = 32,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [2*LANE_W-1:0]   in_data,
    input  logic                  sat_en,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*OUT_W-1:0]    out_data,
    output logic [1:0]            out_sat,
    output logic [1:0]            sticky_sat,
    input  logic                  clr_sticky,
    output logic [15:0]           drop_cnt
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 2 * OUT_W + 2;

    localparam logic [OUT_W-1:0] POS_CLAMP = {1'b0, {(OUT_W-1){1'b1}}};
`ifdef DSP_PACK_SYMMETRIC_SAT_EN
    localparam logic [OUT_W-1:0] NEG_CLAMP = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
`else
    localparam logic [OUT_W-1:0] NEG_CLAMP = {1'b1, {(OUT_W-1){1'b0}}};
`endif

    logic [1:0][OUT_W-1:0] w_lane_res;
    logic [1:0]            w_lane_ovf;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_occupancy;
    logic [EW-1:0]         w_head;

    logic [2*OUT_W-1:0]    r_pipe_data;
    logic [1:0]            r_pipe_sat;
    logic                  r_pipe_valid;
    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic [1:0]            r_sticky;
    logic [15:0]           r_drop;

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [LANE_W-1:0] w_lane;
        logic              w_hi_ovf;

        assign w_lane = in_data[g*LANE_W +: LANE_W];
        // In range only when every bit from the output sign bit upward agrees.
        assign w_hi_ovf = !((&w_lane[LANE_W-1:OUT_W-1]) || !(|w_lane[LANE_W-1:OUT_W-1]));

`ifdef DSP_PACK_SYMMETRIC_SAT_EN
        logic w_is_min;
        assign w_is_min = (&w_lane[LANE_W-1:OUT_W-1]) && (w_lane[OUT_W-2:0] == '0);
        assign w_lane_ovf[g] = w_hi_ovf || w_is_min;
`else
        assign w_lane_ovf[g] = w_hi_ovf;
`endif

        assign w_lane_res[g] = (w_lane_ovf[g] && sat_en)
                             ? (w_lane[LANE_W-1] ? NEG_CLAMP : POS_CLAMP)
                             : w_lane[OUT_W-1:0];
    end

    // Space is reserved at acceptance, so the pipe register can always push.
    assign w_occupancy = r_count + CW'(r_pipe_valid);
    assign in_ready    = w_occupancy < CW'(FIFO_DEPTH);
    assign w_accept    = in_valid && in_ready;
    assign w_push      = r_pipe_valid;
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid && out_ready;

    assign w_head     = r_mem[r_rptr];
    assign out_data   = w_head[2*OUT_W-1:0];
    assign out_sat    = w_head[EW-1:2*OUT_W];
    assign sticky_sat = r_sticky;
    assign drop_cnt   = r_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
            r_pipe_sat   <= '0;
        end else begin
            r_pipe_valid <= w_accept;
            if (w_accept) begin
                r_pipe_data <= {w_lane_res[1], w_lane_res[0]};
                r_pipe_sat  <= w_lane_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {r_pipe_sat, r_pipe_data};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sticky <= 2'b00;
            r_drop   <= 16'h0000;
        end else begin
            // A coinciding set takes priority over the clear.
            r_sticky <= (clr_sticky ? 2'b00 : r_sticky) | (w_accept ? w_lane_ovf : 2'b00);
            if (in_valid && !in_ready && (r_drop != 16'hFFFF)) begin
                r_drop <= r_drop + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_dsp_fractured_result_sat_packer.sv
// Directed bench for dsp_fractured_result_sat_packer with a scoreboard of expected packed words.
module tb_dsp_fractured_result_sat_packer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        sat_en;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_sat;
    logic [1:0]  sticky_sat;
    logic        clr_sticky;
    logic [15:0] drop_cnt;

    int n_cmp;
    int n_err;
    logic [33:0] sb[$];

    dsp_fractured_result_sat_packer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .sat_en     (sat_en),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .sticky_sat (sticky_sat),
        .clr_sticky (clr_sticky),
        .drop_cnt   (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {overflow, 16-bit result} for one signed 32-bit lane.
    function automatic logic [16:0] lane_model(input logic [31:0] lane, input logic se);
        int v;
        int lo;
        logic ovf;
        logic [15:0] r;
        v = int'($signed(lane));
`ifdef DSP_PACK_SYMMETRIC_SAT_EN
        lo = -32767;
`else
        lo = -32768;
`endif
        ovf = (v > 32767) || (v < lo);
        if (ovf && se) r = (v < 0) ? 16'(lo) : 16'h7FFF;
        else           r = lane[15:0];
        return {ovf, r};
    endfunction

    function automatic logic [33:0] word_model(input logic [63:0] d, input logic se);
        logic [16:0] l1;
        logic [16:0] l0;
        l1 = lane_model(d[63:32], se);
        l0 = lane_model(d[31:0], se);
        return {l1[16], l0[16], l1[15:0], l0[15:0]};
    endfunction

    // Present a word; bench states whether it should be accepted.
    task automatic drive(input string tag, input logic [63:0] d, input logic se, input logic acc);
        in_valid = 1'b1;
        in_data  = d;
        sat_en   = se;
        chk(tag, {63'd0, in_ready}, {63'd0, acc});
        if (acc) sb.push_back(word_model(d, se));
    endtask

    // Advance one cycle; any handshake seen at the falling edge is scored.
    task automatic cycle();
        logic [33:0] exp;
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
            exp = (sb.size() > 0) ? sb.pop_front() : 'x;
            chk("sb_pop", {30'd0, out_sat, out_data}, {30'd0, exp});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (sb.size() > 0 && k < 20) begin
            cycle();
            k++;
        end
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        sat_en     = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;

        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sticky",    {62'd0, sticky_sat}, 64'd0);
        chk("rst_drop",      {48'd0, drop_cnt},  64'd0);
        chk("rst_out_data",  {32'd0, out_data},  64'd0);

        // Pass-through and two-cycle latency
        out_ready = 1'b1;
        drive("pass_acc", {32'h0000_1234, 32'hFFFF_FFFE}, 1'b1, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("pass_n1_valid", {63'd0, out_valid}, 64'd0);
        cycle();
        chk("pass_n2_valid", {63'd0, out_valid}, 64'd1);
        chk("pass_data", {32'd0, out_data}, {32'd0, 32'h1234_FFFE});
        chk("pass_sat",  {62'd0, out_sat}, 64'd0);
        cycle();

        // Saturation with clamp
        drive("sat1_acc", {32'h0001_0000, 32'hFFFE_0000}, 1'b1, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("sat1_sticky", {62'd0, sticky_sat}, 64'd3);
        cycle();
        chk("sat1_valid", {63'd0, out_valid}, 64'd1);
`ifdef DSP_PACK_SYMMETRIC_SAT_EN
        chk("sat1_data", {32'd0, out_data}, {32'd0, 32'h7FFF_8001});
`else
        chk("sat1_data", {32'd0, out_data}, {32'd0, 32'h7FFF_8000});
`endif
        chk("sat1_sat", {62'd0, out_sat}, 64'd3);
        cycle();

        // Same lanes truncated
        drive("sat0_acc", {32'h0001_0000, 32'hFFFE_0000}, 1'b0, 1'b1);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("sat0_data", {32'd0, out_data}, 64'd0);
        chk("sat0_sat",  {62'd0, out_sat}, 64'd3);
        cycle();

        // Sticky set/clear collision: lane0 sets while both are cleared
        clr_sticky = 1'b1;
        drive("coll_acc", {32'h0000_0005, 32'h0000_8000}, 1'b1, 1'b1);
        cycle();
        in_valid   = 1'b0;
        clr_sticky = 1'b0;
        chk("coll_sticky", {62'd0, sticky_sat}, 64'd1);
        clr_sticky = 1'b1;
        cycle();
        clr_sticky = 1'b0;
        chk("clr_sticky", {62'd0, sticky_sat}, 64'd0);
        drain("coll_drain");

        // Backpressure: four fit, two dropped
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive($sformatf("bp_acc%0d", i), {32'(i), 32'(i)}, 1'b1, i <= 4);
            cycle();
        end
        in_valid = 1'b0;
        chk("bp_drop",     {48'd0, drop_cnt},  64'd2);
        chk("bp_in_ready", {63'd0, in_ready},  64'd0);
        chk("bp_valid",    {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        drain("bp_drain");
        chk("bp_ready_back", {63'd0, in_ready},  64'd1);
        chk("bp_empty",      {63'd0, out_valid}, 64'd0);
        chk("bp_drop_hold",  {48'd0, drop_cnt},  64'd2);

        // Reset with three words buffered
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive($sformatf("mid_acc%0d", i), {32'(i + 16'h40), 32'(i + 16'h50)}, 1'b1, 1'b1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("mid_buffered", {63'd0, out_valid}, 64'd1);
        reset = 1'b1;
        sb.delete();
        cycle();
        reset = 1'b0;
        out_ready = 1'b1;
        chk("mid_valid",    {63'd0, out_valid}, 64'd0);
        chk("mid_drop",     {48'd0, drop_cnt},  64'd0);
        chk("mid_in_ready", {63'd0, in_ready},  64'd1);
        cycle();
        cycle();
        chk("mid_idle", {63'd0, out_valid}, 64'd0);
        drive("mid_new_acc", {32'hFFFF_8000, 32'h0000_7FFF}, 1'b1, 1'b1);
        cycle();
        in_valid = 1'b0;
        chk("mid_new_n1", {63'd0, out_valid}, 64'd0);
        cycle();
        chk("mid_new_n2", {63'd0, out_valid}, 64'd1);
        drain("mid_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
